// File: rtl/codel_dequeue.sv
// CoDel dequeue controller: pops the packet FIFO and drops or forwards each head packet.
// Forwarded packets appear 1 cycle after the pop; drop decisions ignore egress backpressure.
module codel_dequeue #(
  parameter int unsigned TARGET   = 5,
  parameter int unsigned INTERVAL = 100,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned TIME_W   = 16,
  parameter int unsigned PKT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TIME_W-1:0]  i__time_now,
  input  logic               i__fifo_empty,
  input  logic [PKT_W-1:0]   i__fifo_packet,
  input  logic [TIME_W-1:0]  i__fifo_time_stamp,
  output logic               o__fifo_read,
  output logic               o__packet_valid,
  output logic [PKT_W-1:0]   o__packet,
  input  logic               i__packet_ready,
  output logic               o__drop_pulse,
  output logic               o__dropping,
  output logic [COUNT_W-1:0] o__drop_count
);

  typedef enum logic {NOT_DROPPING, DROPPING} state_t;

  localparam logic [TIME_W-1:0]  TIME_MSB  = {1'b1, {(TIME_W-1){1'b0}}};
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // round(INTERVAL/sqrt(n)) = largest k with n*(2k-1)^2 <= 4*INTERVAL^2
  function automatic logic [16*TIME_W-1:0] build_cl_tab();
    logic [16*TIME_W-1:0] tab;
    longint unsigned      lim;
    longint unsigned      x;
    longint unsigned      r;
    longint unsigned      cand;
    tab = '0;
    lim = 64'd4 * 64'(INTERVAL) * 64'(INTERVAL);
    for (int n = 1; n <= 16; n++) begin
      x = lim / 64'(n);
      r = 0;
      for (int b = 31; b >= 0; b--) begin
        cand = r | (64'd1 << b);
        if (cand * cand <= x) r = cand;
      end
      tab[(n-1)*TIME_W +: TIME_W] = TIME_W'((r + 64'd1) / 64'd2);
    end
    return tab;
  endfunction

  localparam logic [16*TIME_W-1:0] CL_TAB = build_cl_tab();

  function automatic logic [TIME_W-1:0] cl_lookup(input logic [COUNT_W-1:0] n);
    int idx;
    idx = int'(n);
    if (idx > 16) idx = 16;
    if (idx < 1) idx = 1;
    return CL_TAB[(idx-1)*TIME_W +: TIME_W];
  endfunction

  function automatic logic time_ge(input logic [TIME_W-1:0] a, input logic [TIME_W-1:0] b);
    return ((a - b) & TIME_MSB) == '0;
  endfunction

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [TIME_W-1:0]    drop_next_q, drop_next_d;
  logic [TIME_W-1:0]    first_above_q, first_above_d;
  logic                 fav_q, fav_d;
  logic [PKT_W-1:0]     pkt_q, pkt_d;
  logic                 vld_q, vld_d;
  logic                 pulse_q, pulse_d;

  logic                 head, out_free, above, ok, now_ge_dn, drop, read, fwd;
  logic [TIME_W-1:0]    sojourn, dn_diff;
  logic [COUNT_W-1:0]   cnt_inc, cnt_re;

  always_comb begin
    head      = !i__fifo_empty;
    out_free  = !vld_q || i__packet_ready;
    sojourn   = i__time_now - i__fifo_time_stamp;
    above     = sojourn >= TIME_W'(TARGET);
    ok        = above && fav_q && time_ge(i__time_now, first_above_q);
    dn_diff   = i__time_now - drop_next_q;
    now_ge_dn = (dn_diff & TIME_MSB) == '0;
    cnt_inc   = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
    cnt_re    = (count_q > COUNT_W'(2) && 32'(dn_diff) < 32'(16 * INTERVAL))
              ? count_q - COUNT_W'(2) : COUNT_W'(1);
    drop      = head && ((state_q == DROPPING) ? (ok && now_ge_dn) : ok);
    read      = reset && head && (drop || out_free);
    fwd       = read && !drop;

    state_d       = state_q;
    count_d       = count_q;
    drop_next_d   = drop_next_q;
    first_above_d = first_above_q;
    fav_d         = fav_q;

    if (!head) begin
      fav_d   = 1'b0;
      state_d = NOT_DROPPING;
    end else if (read) begin
      if (!above) begin
        fav_d = 1'b0;
      end else if (!fav_q) begin
        fav_d         = 1'b1;
        first_above_d = i__time_now + TIME_W'(INTERVAL);
      end
      case (state_q)
        NOT_DROPPING: begin
          if (ok) begin
            state_d     = DROPPING;
            count_d     = cnt_re;
            drop_next_d = i__time_now + cl_lookup(cnt_re);
          end
        end
        DROPPING: begin
          if (!ok) begin
            state_d = NOT_DROPPING;
          end else if (now_ge_dn) begin
            count_d     = cnt_inc;
            drop_next_d = drop_next_q + cl_lookup(cnt_inc);
          end
        end
        default: state_d = NOT_DROPPING;
      endcase
    end

    pkt_d   = fwd ? i__fifo_packet : pkt_q;
    vld_d   = fwd ? 1'b1 : (i__packet_ready ? 1'b0 : vld_q);
    pulse_d = read && drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= NOT_DROPPING;
      count_q       <= '0;
      drop_next_q   <= '0;
      first_above_q <= '0;
      fav_q         <= 1'b0;
      pkt_q         <= '0;
      vld_q         <= 1'b0;
      pulse_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      drop_next_q   <= drop_next_d;
      first_above_q <= first_above_d;
      fav_q         <= fav_d;
      pkt_q         <= pkt_d;
      vld_q         <= vld_d;
      pulse_q       <= pulse_d;
    end
  end

  assign o__fifo_read    = read;
  assign o__packet_valid = vld_q;
  assign o__packet       = pkt_q;
  assign o__drop_pulse   = pulse_q;
  assign o__dropping     = (state_q == DROPPING);
  assign o__drop_count   = count_q;

endmodule

// File: tb/tb_codel_dequeue.sv
// Directed bench for codel_dequeue: TARGET=5, INTERVAL=100, 16-bit time, 32-bit packets.
module tb_codel_dequeue;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] now;
  logic        empty;
  logic [31:0] fpkt;
  logic [15:0] ts;
  logic        rd;
  logic        vld;
  logic [31:0] opkt;
  logic        ready;
  logic        pulse;
  logic        dropping;
  logic [7:0]  cnt;

  int checks   = 0;
  int failures = 0;

  codel_dequeue #(.TARGET(5), .INTERVAL(100), .COUNT_W(8), .TIME_W(16), .PKT_W(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .i__time_now        (now),
    .i__fifo_empty      (empty),
    .i__fifo_packet     (fpkt),
    .i__fifo_time_stamp (ts),
    .o__fifo_read       (rd),
    .o__packet_valid    (vld),
    .o__packet          (opkt),
    .i__packet_ready    (ready),
    .o__drop_pulse      (pulse),
    .o__dropping        (dropping),
    .o__drop_count      (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tag_pkt(input logic [15:0] t);
    return {16'hC0DE, t};
  endfunction

  // Present a head packet, check the pop strobe, then advance one clock.
  task automatic pop(input logic [15:0] t_now, input logic [15:0] t_ts, input logic exp_rd,
                     input string tag);
    now   = t_now;
    ts    = t_ts;
    fpkt  = tag_pkt(t_now);
    empty = 1'b0;
    #1;
    check({tag, "_rd"}, 32'(rd), 32'(exp_rd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; empty = 1'b0; now = 16'd0; ts = 16'd0; fpkt = 32'd0; ready = 1'b1;
    #2;
    check("rst_rd",    32'(rd), 0);
    check("rst_vld",   32'(vld), 0);
    check("rst_pkt",   opkt, 0);
    check("rst_pulse", 32'(pulse), 0);
    check("rst_drop",  32'(dropping), 0);
    check("rst_cnt",   32'(cnt), 0);
    @(posedge clk); #1;
    reset = 1'b1; empty = 1'b1;
    @(posedge clk); #1;

    // simple forward, 1-cycle latency
    pop(16'd23, 16'd20, 1'b1, "t1");
    empty = 1'b1;
    check("t1_vld",   32'(vld), 1);
    check("t1_pkt",   opkt, tag_pkt(16'd23));
    check("t1_pulse", 32'(pulse), 0);
    check("t1_drop",  32'(dropping), 0);
    @(posedge clk); #1;
    check("t1_drain", 32'(vld), 0);

    // sojourn 8 backlog: first_above=110
    for (int t = 10; t < 110; t++) begin
      pop(16'(t), 16'(t - 8), 1'b1, "t2");
      check("t2_pulse", 32'(pulse), 0);
      check("t2_pkt",   opkt, tag_pkt(16'(t)));
    end
    pop(16'd110, 16'd102, 1'b1, "t2d");
    check("t2d_pulse", 32'(pulse), 1);
    check("t2d_drop",  32'(dropping), 1);
    check("t2d_cnt",   32'(cnt), 1);
    check("t2d_vld",   32'(vld), 0);

    // drop_next=210
    for (int t = 111; t < 210; t++) begin
      pop(16'(t), 16'(t - 8), 1'b1, "t3");
      check("t3_pulse", 32'(pulse), 0);
      check("t3_drop",  32'(dropping), 1);
    end
    pop(16'd210, 16'd202, 1'b1, "t3d");
    check("t3d_pulse", 32'(pulse), 1);
    check("t3d_cnt",   32'(cnt), 2);
    for (int t = 211; t < 250; t++) begin
      pop(16'(t), 16'(t - 8), 1'b1, "t3b");
      check("t3b_pulse", 32'(pulse), 0);
    end
    pop(16'd250, 16'd247, 1'b1, "t3x");
    check("t3x_drop",  32'(dropping), 0);
    check("t3x_vld",   32'(vld), 1);
    check("t3x_pkt",   opkt, tag_pkt(16'd250));
    check("t3x_cnt",   32'(cnt), 2);
    check("t3x_pulse", 32'(pulse), 0);

    // time wrap: sojourn 18, first_above=0x0066
    pop(16'h0002, 16'hFFF0, 1'b1, "t4");
    check("t4_pulse", 32'(pulse), 0);
    check("t4_vld",   32'(vld), 1);
    for (int t = 3; t < 16'h66; t++) begin
      pop(16'(t), 16'(t - 18), 1'b1, "t4b");
      check("t4b_pulse", 32'(pulse), 0);
    end
    pop(16'h0066, 16'h0054, 1'b1, "t4d");
    check("t4d_pulse", 32'(pulse), 1);
    check("t4d_cnt",   32'(cnt), 1);
    check("t4d_drop",  32'(dropping), 1);

    // backpressure; drop_next=0x00CA
    pop(16'h0067, 16'h0055, 1'b1, "t5f");
    check("t5f_vld", 32'(vld), 1);
    check("t5f_pkt", opkt, tag_pkt(16'h0067));
    ready = 1'b0;
    pop(16'h0068, 16'h0056, 1'b0, "t5s");
    check("t5s_vld",   32'(vld), 1);
    check("t5s_pkt",   opkt, tag_pkt(16'h0067));
    check("t5s_pulse", 32'(pulse), 0);
    pop(16'h00CA, 16'h00B8, 1'b1, "t5d");
    check("t5d_pulse", 32'(pulse), 1);
    check("t5d_cnt",   32'(cnt), 2);
    check("t5d_pkt",   opkt, tag_pkt(16'h0067));
    check("t5d_vld",   32'(vld), 1);

    // asynchronous reset while DROPPING with a head present
    reset = 1'b0;
    #1;
    check("t6_rd",    32'(rd), 0);
    check("t6_vld",   32'(vld), 0);
    check("t6_pkt",   opkt, 0);
    check("t6_pulse", 32'(pulse), 0);
    check("t6_drop",  32'(dropping), 0);
    check("t6_cnt",   32'(cnt), 0);
    @(posedge clk); #1;
    reset = 1'b1; ready = 1'b1;
    pop(16'h0200, 16'h01EE, 1'b1, "t6a");
    check("t6a_pulse", 32'(pulse), 0);
    check("t6a_drop",  32'(dropping), 0);
    check("t6a_vld",   32'(vld), 1);
    pop(16'h0263, 16'h0251, 1'b1, "t6b");
    check("t6b_pulse", 32'(pulse), 0);
    pop(16'h0264, 16'h0252, 1'b1, "t6c");
    check("t6c_pulse", 32'(pulse), 1);
    check("t6c_drop",  32'(dropping), 1);
    check("t6c_cnt",   32'(cnt), 1);

    // empty FIFO leaves DROPPING but keeps count
    empty = 1'b1;
    @(posedge clk); #1;
    check("t7_drop", 32'(dropping), 0);
    check("t7_cnt",  32'(cnt), 1);
    check("t7_rd",   32'(rd), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/codel_dequeue.md
Name: codel_dequeue

Overview:
- Dequeue-side CoDel controller. Sits directly downstream of the packet FIFO, which stores each packet with its enqueue time stamp.
- Pops head packets from the FIFO and computes each packet's sojourn time against the free-running time counter.
- Runs the CoDel drop state machine: each popped packet is either forwarded to the egress through a one-entry output register, or dropped.
- Exports drop status and a drop count for statistics.

Parameters:
- TARGET, 5, sojourn threshold in TimeCtr ticks.
- INTERVAL, 100, CoDel interval in TimeCtr ticks.
- COUNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- i__time_now  in  $bits(TimeCtr)  free-running current time.
- i__fifo_empty  in  1  FIFO has no head packet.
- i__fifo_packet  in  $bits(Packet)  FIFO head packet; first-word-fall-through, valid when not empty.
- i__fifo_time_stamp  in  $bits(TimeCtr)  enqueue time of the head packet.
- o__fifo_read  out  1  pops the FIFO head this cycle.
- o__packet_valid  out  1  output register holds a forwarded packet.
- o__packet  out  $bits(Packet)  forwarded packet.
- i__packet_ready  in  1  egress accepts o__packet this cycle.
- o__drop_pulse  out  1  one-cycle pulse, registered, one cycle after a drop pop.
- o__dropping  out  1  state machine is in DROPPING.
- o__drop_count  out  COUNT_W  current CoDel count.

Behaviour:
Reset:
- reset=0 asynchronously clears all registers: state=NOT_DROPPING, count=0, drop_next=0, first_above_valid=0, first_above=0, o__packet_valid=0, o__drop_pulse=0.
- o__packet resets to 0.

Sojourn and time arithmetic:
- sojourn = i__time_now - i__fifo_time_stamp, modulo 2^$bits(TimeCtr). Wrap is handled naturally.
- All "a >= b" time comparisons are wrap-aware: true when the MSB of (a - b) is 0.

Pop rule:
- head = !i__fifo_empty.
- out_free = !o__packet_valid || i__packet_ready.
- o__fifo_read = head && (drop_decision || out_free). A drop never waits on egress backpressure.
- At most one pop per cycle. No decision is made and no state updates while the FIFO is empty.

ok_to_drop (evaluated combinationally on the head packet, committed only on pop):
- sojourn < TARGET: ok=0; first_above_valid <= 0.
- Otherwise, if first_above_valid=0: ok=0; first_above <= now+INTERVAL; first_above_valid <= 1.
- Otherwise: ok = (now >= first_above).

Control law:
- CL(n) = round(INTERVAL/sqrt(min(n,16))), held in a 16-entry table computed at elaboration.
- With INTERVAL=100: CL(1)=100, CL(2)=71, CL(3)=58, CL(4)=50, CL(16)=25.
- count saturates at 2^COUNT_W-1.

FSM:
- NOT_DROPPING, on pop with ok=1:
  - drop the packet and go to DROPPING.
  - count <= (count>2 && (now - drop_next) < 16*INTERVAL) ? count-2 : 1.
  - drop_next <= now + CL(new count).
- NOT_DROPPING, on pop with ok=0: forward the packet.
- DROPPING, on pop with ok=0: go to NOT_DROPPING and forward the packet.
- DROPPING, on pop with ok=1 and now >= drop_next: drop the packet; count <= count+1; drop_next <= drop_next + CL(count+1).
- DROPPING, on pop with ok=1 and now < drop_next: forward the packet.
- FIFO empty in any state: first_above_valid <= 0. In DROPPING, also go to NOT_DROPPING. count and drop_next are retained.

Output register:
- A forward pop loads o__packet and sets o__packet_valid=1 on the next edge.
- Latency: 1 cycle from pop to visibility.
- o__packet_valid clears when i__packet_ready=1 and no new forward pop occurs.
- Load and drain in the same cycle gives back-to-back throughput of 1 packet/cycle.
- o__packet is held stable while o__packet_valid=1 && !i__packet_ready.

Reset mid-operation:
- The output-register packet is discarded. FIFO contents are untouched by this block.
- o__fifo_read is low while reset=0.

Test Plan (TARGET=5, INTERVAL=100, 16-bit TimeCtr):
1. Head ts=20, now=23, ready=1 -> read=1 same cycle; o__packet_valid=1 next cycle with that packet; no drop.
2. Continuous backlog, sojourn=8 from now=10:
   - first_above=110; packets forwarded through now=109.
   - Pop at now=110 -> dropped, o__drop_pulse at 111, o__dropping=1, count=1, drop_next=210.
3. Continue test 2:
   - Pops at 111..209 forwarded.
   - Pop at now=210 -> dropped, count=2, drop_next=281.
   - Sojourn falls to 3 at now=250 -> NOT_DROPPING, that packet forwarded.
4. Wrap: ts=0xFFF0, now=0x0002 -> sojourn=18, treated as above TARGET. first_above=0x0066.
5. Backpressure:
   - i__packet_ready=0 with o__packet_valid=1 and forward decision -> read=0, o__packet stable.
   - Same stall with a drop decision -> read=1, drop_pulse next cycle.
6. Assert reset=0 mid-DROPPING -> all outputs 0 immediately. After release, the first above-TARGET packet starts a new first_above timer; it is not dropped.
